// File: rtl/isram_rslave.sv
// isram_rslave: instruction-side AR/R read slave in front of a synchronous
// 64-bit instruction SRAM. One request in flight; fixed (or optionally
// jittered) wait before the SRAM read; returns the addressed 32-bit word.
// Optional feature: define ISRAM_RAND_DELAY_EN to add 0..3 LFSR-driven
// wait cycles to every OKAY fetch.
module isram_rslave #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter logic [63:0] SIZE_BYTES = 64'h0000_0000_0800_0000,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned MEM_AW     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isr_ARVALID,
  output logic              isr_ARREADY,
  input  logic [63:0]       isr_ARADDR,
  input  logic [2:0]        isr_ARPORT,
  output logic              isr_RVALID,
  input  logic              isr_RREADY,
  output logic [63:0]       isr_RDATA,
  output logic [1:0]        isr_RRESP,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [63:0]       mem_rdata
);

  localparam logic [63:0] END_ADDR = BASE_ADDR + SIZE_BYTES;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_CAPT, S_RESP} state_t;

  state_t            state;
  logic [4:0]        wait_cnt;
  logic              sel_hi;
  logic [1:0]        req_resp;
  logic [4:0]        wait_tot;
  logic [MEM_AW-1:0] word_idx;

`ifdef ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR supplying 0..3 extra wait cycles
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign wait_tot = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
  assign wait_tot = 5'(LATENCY);
`endif

  assign word_idx = MEM_AW'((isr_ARADDR - BASE_ADDR) >> 3);

  // Classify the presented request: range beats alignment beats port check
  always_comb begin
    req_resp = 2'b00;
    if (isr_ARADDR < BASE_ADDR || isr_ARADDR >= END_ADDR)
      req_resp = 2'b11;
    else if (isr_ARADDR[1:0] != 2'b00 || !isr_ARPORT[2])
      req_resp = 2'b10;
  end

  // Request FSM; every output is a register written here
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      isr_ARREADY <= 1'b0;
      isr_RVALID  <= 1'b0;
      isr_RDATA   <= '0;
      isr_RRESP   <= 2'b00;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      wait_cnt    <= '0;
      sel_hi      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // ARREADY comes up one cycle after reset and stays up while idle
          isr_ARREADY <= 1'b1;
          if (isr_ARVALID && isr_ARREADY) begin
            isr_ARREADY <= 1'b0;
            sel_hi      <= isr_ARADDR[2];
            if (req_resp != 2'b00) begin
              // Errors answer immediately and never touch the SRAM
              isr_RDATA  <= '0;
              isr_RRESP  <= req_resp;
              isr_RVALID <= 1'b1;
              state      <= S_RESP;
            end else begin
              mem_addr <= word_idx;
              if (wait_tot == 5'd0) begin
                mem_en <= 1'b1;
                state  <= S_READ;
              end else begin
                wait_cnt <= wait_tot;
                state    <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 5'd1) begin
            mem_en <= 1'b1;
            state  <= S_READ;
          end else begin
            wait_cnt <= wait_cnt - 5'd1;
          end
        end
        S_READ: begin
          mem_en <= 1'b0;
          state  <= S_CAPT;
        end
        S_CAPT: begin
          isr_RDATA  <= {32'h0, sel_hi ? mem_rdata[63:32] : mem_rdata[31:0]};
          isr_RRESP  <= 2'b00;
          isr_RVALID <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (isr_RREADY) begin
            isr_RVALID  <= 1'b0;
            isr_RDATA   <= '0;
            isr_ARREADY <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isram_rslave.sv
// Directed bench for isram_rslave: instance 0 runs LATENCY=2, instance 1
// runs LATENCY=0; both are backed by a small behavioural SRAM.
module tb_isram_rslave;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid [2];
  logic        arready [2];
  logic [63:0] araddr  [2];
  logic [2:0]  arport  [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [63:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        mem_en  [2];
  logic [23:0] mem_addr[2];
  logic [63:0] mem_rdata[2];

  logic [63:0] mem [16];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          men_cnt0 = 0;

  always #5 clk = ~clk;

  isram_rslave #(.LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .isr_ARVALID(arvalid[0]), .isr_ARREADY(arready[0]),
    .isr_ARADDR(araddr[0]), .isr_ARPORT(arport[0]),
    .isr_RVALID(rvalid[0]), .isr_RREADY(rready[0]),
    .isr_RDATA(rdata[0]), .isr_RRESP(rresp[0]),
    .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]));

  isram_rslave #(.LATENCY(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .isr_ARVALID(arvalid[1]), .isr_ARREADY(arready[1]),
    .isr_ARADDR(araddr[1]), .isr_ARPORT(arport[1]),
    .isr_RVALID(rvalid[1]), .isr_RREADY(rready[1]),
    .isr_RDATA(rdata[1]), .isr_RRESP(rresp[1]),
    .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]));

  // SRAM model: data valid the cycle after mem_en
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en[0]) mem_rdata[0] <= mem[mem_addr[0][3:0]];
    if (mem_en[1]) mem_rdata[1] <= mem[mem_addr[1][3:0]];
  end

  always @(negedge clk) if (mem_en[0]) men_cnt0 <= men_cnt0 + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one AR, then count cycles (n+1 = 1) to mem_en and to RVALID
  task automatic fetch(input int d, input logic [63:0] addr, input logic [2:0] port,
                       output int lat, output int men_at,
                       output logic [63:0] data, output logic [1:0] resp);
    bit ok = 0;
    lat = -1; men_at = -1; data = 'x; resp = 'x;
    arvalid[d] = 1'b1; araddr[d] = addr; arport[d] = port;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (arready[d]) ok = 1;
      @(posedge clk); #1;
    end
    arvalid[d] = 1'b0;
    if (!ok) begin
      chk("ar_timeout", 64'd0, 64'd1);
      return;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mem_en[d] && men_at < 0) men_at = i;
      if (rvalid[d]) begin
        lat = i; data = rdata[d]; resp = rresp[d];
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, men_at, m0;
    logic [63:0] data;
    logic [1:0]  resp;
    int hs[$], rh[$];
    bit drop;
    logic [63:0] last_d;

    mem[0]  = 64'h1234_5678_0000_0413;
    mem[1]  = 64'hCAFE_BABE_DEAD_BEEF;
    mem[15] = 64'h0BAD_F00D_0000_0073;
    for (int d = 0; d < 2; d++) begin
      arvalid[d] = 0; araddr[d] = 0; arport[d] = 0; rready[d] = 1;
      mem_rdata[d] = 0;
    end
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", {63'd0, arready[0]}, 64'd0);
    chk("rst_rvalid",  {63'd0, rvalid[0]},  64'd0);
    chk("rst_rdata",   rdata[0],            64'd0);
    chk("rst_rresp",   {62'd0, rresp[0]},   64'd0);
    chk("rst_mem_en",  {63'd0, mem_en[0]},  64'd0);
    chk("rst_mem_addr",{40'd0, mem_addr[0]},64'd0);
    chk("rst_rvalid1", {63'd0, rvalid[1]},  64'd0);
    @(posedge clk); #1 rst = 0;

    // basic fetch, lower word
    fetch(0, 64'h8000_0000, 3'b100, lat, men_at, data, resp);
    chk("basic_lat",   lat,    5);
    chk("basic_menat", men_at, 3);
    chk("basic_data",  data,   64'h0000_0000_0000_0413);
    chk("basic_resp",  {62'd0, resp}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("exit_rvalid",  {63'd0, rvalid[0]},  64'd0);
    chk("exit_arready", {63'd0, arready[0]}, 64'd1);
    chk("exit_rdata",   rdata[0],            64'd0);

    // upper word select, second word, top-of-window word
    fetch(0, 64'h8000_0004, 3'b100, lat, men_at, data, resp);
    chk("upper_data", data, 64'h0000_0000_1234_5678);
    fetch(0, 64'h8000_000C, 3'b101, lat, men_at, data, resp);
    chk("word1_data", data, 64'h0000_0000_CAFE_BABE);
    fetch(0, 64'h87FF_FFF8, 3'b100, lat, men_at, data, resp);
    chk("top_resp", {62'd0, resp}, 64'd0);
    chk("top_data", data, 64'h0000_0000_0000_0073);

    // error responses: one cycle, no SRAM access
    m0 = men_cnt0;
    fetch(0, 64'h7FFF_FFFC, 3'b100, lat, men_at, data, resp);
    chk("decerr_lo_lat",  lat, 1);
    chk("decerr_lo_resp", {62'd0, resp}, 64'd3);
    chk("decerr_lo_data", data, 64'd0);
    fetch(0, 64'h8800_0000, 3'b100, lat, men_at, data, resp);
    chk("decerr_hi_resp", {62'd0, resp}, 64'd3);
    fetch(0, 64'h7FFF_FFFE, 3'b000, lat, men_at, data, resp);
    chk("decerr_prio", {62'd0, resp}, 64'd3);
    fetch(0, 64'h8000_0002, 3'b100, lat, men_at, data, resp);
    chk("slverr_align_lat",  lat, 1);
    chk("slverr_align_resp", {62'd0, resp}, 64'd2);
    fetch(0, 64'h8000_0000, 3'b000, lat, men_at, data, resp);
    chk("slverr_port_resp", {62'd0, resp}, 64'd2);
    @(posedge clk); #1;
    chk("err_no_mem_en", men_cnt0 - m0, 0);

    // backpressure: RESP held five cycles
    rready[0] = 0;
    fetch(0, 64'h8000_0004, 3'b100, lat, men_at, data, resp);
    chk("bp_lat", lat, 5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rvalid",  {63'd0, rvalid[0]},  64'd1);
      chk("bp_rdata",   rdata[0],            64'h0000_0000_1234_5678);
      chk("bp_rresp",   {62'd0, rresp[0]},   64'd0);
      chk("bp_arready", {63'd0, arready[0]}, 64'd0);
    end
    rready[0] = 1;
    @(negedge clk);
    chk("bp_exit_rvalid",  {63'd0, rvalid[0]},  64'd0);
    chk("bp_exit_arready", {63'd0, arready[0]}, 64'd1);
    @(posedge clk); #1;

    // LATENCY=0 single fetch
    fetch(1, 64'h8000_0000, 3'b100, lat, men_at, data, resp);
    chk("l0_lat",   lat,    3);
    chk("l0_menat", men_at, 1);
    chk("l0_data",  data,   64'h0000_0000_0000_0413);
    @(posedge clk); #1;

    // LATENCY=0 back-to-back with ARVALID held and RREADY high
    arvalid[1] = 1; araddr[1] = 64'h8000_0004; arport[1] = 3'b100;
    drop = 0; last_d = 'x;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (drop) begin arvalid[1] = 0; drop = 0; end
      if (rvalid[1] && rready[1]) begin rh.push_back(cyc); last_d = rdata[1]; end
      if (arvalid[1] && arready[1]) begin
        hs.push_back(cyc);
        if (hs.size() == 2) drop = 1;
      end
    end
    arvalid[1] = 0;
    if (hs.size() == 2 && rh.size() == 2) begin
      chk("b2b_first_lat", rh[0] - hs[0], 3);
      chk("b2b_gap",       hs[1] - rh[0], 1);
      chk("b2b_second_lat",rh[1] - hs[1], 3);
      chk("b2b_data",      last_d, 64'h0000_0000_1234_5678);
    end else begin
      chk("b2b_hs_count", hs.size(), 2);
      chk("b2b_rh_count", rh.size(), 2);
    end
    @(posedge clk); #1;

    // reset during WAIT
    arvalid[0] = 1; araddr[0] = 64'h8000_0000; arport[0] = 3'b100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready[0]) break;
    end
    @(posedge clk); #1;
    arvalid[0] = 0;
    rst = 1;
    @(posedge clk); #1 rst = 0;
    m0 = men_cnt0;
    @(negedge clk);
    chk("mrst_rvalid",  {63'd0, rvalid[0]},  64'd0);
    chk("mrst_mem_en",  {63'd0, mem_en[0]},  64'd0);
    chk("mrst_arready0",{63'd0, arready[0]}, 64'd0);
    @(negedge clk);
    chk("mrst_arready1",{63'd0, arready[0]}, 64'd1);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rvalid[0]) lat++;
    end
    chk("mrst_no_resp",   lat, 0);
    chk("mrst_no_mem_en", men_cnt0 - m0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
